// File: rtl/vga_rx_capture_8b.sv
// vga_rx_capture_8b: VGA timing recovery, format lock and X/Y pixel capture.
// Define VGA_RX_ERRCNT_EN to enable the saturating lock-loss counter on ERR_CNT.
module vga_rx_capture_8b #(
  parameter int H_W         = 11,
  parameter int V_W         = 10,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic           VGA_CLK,
  input  logic           VGA_RST_N,
  input  logic           VGA_HSYNC,
  input  logic           VGA_VSYNC,
  input  logic           VGA_DE,
  input  logic [7:0]     VGA_R,
  input  logic [7:0]     VGA_G,
  input  logic [7:0]     VGA_B,
  output logic           PIX_VALID,
  output logic [H_W-1:0] PIX_X,
  output logic [V_W-1:0] PIX_Y,
  output logic [23:0]    PIX_RGB,
  output logic           FRAME_START,
  output logic           LOCKED,
  output logic [H_W-1:0] H_ACTIVE,
  output logic [V_W-1:0] V_ACTIVE,
  output logic [H_W-1:0] H_TOTAL,
  output logic [15:0]    ERR_CNT
);
  localparam int T_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_MEAS, S_CHECK, S_LOCK} state_t;
  state_t state, state_nx;
  logic hs1, hs2, vs1, vs2, de1, de2;
  logic [23:0] rgb1;
  logic [H_W-1:0] h_cnt, x, x_cur, f_h, ref_h, ref_h_nx;
  logic [V_W-1:0] f_v, ref_v, ref_v_nx;
  logic [3:0] cnt, cnt_nx;
  logic [T_W-1:0] to_cnt;
  logic bad, hs_fall, vs_fall, de_rise, de_fall, match, timeout, locked, pix_bad;
  assign hs_fall = hs2 & ~hs1;
  assign vs_fall = vs2 & ~vs1;
  assign de_rise = ~de2 & de1;
  assign de_fall = de2 & ~de1;
  assign x_cur   = de_rise ? '0 : x;
  assign locked  = state == S_LOCK;
  assign match   = !bad && f_h != '0 && f_v != '0 && f_h == ref_h && f_v == ref_v;
  // the cycle that finally brings an HSYNC fall must not be mistaken for a timeout
  assign timeout = to_cnt == T_W'(TIMEOUT) && !hs_fall;
  assign pix_bad = locked && de1 && (x_cur >= ref_h || f_v >= ref_v);
  assign LOCKED   = locked;
  assign H_ACTIVE = locked ? ref_h : '0;
  assign V_ACTIVE = locked ? ref_v : '0;
  always_comb begin
    state_nx = state;
    ref_h_nx = ref_h;
    ref_v_nx = ref_v;
    cnt_nx   = cnt;
    if (timeout) begin
      state_nx = S_IDLE;
      ref_h_nx = '0;
      ref_v_nx = '0;
      cnt_nx   = '0;
    end else if (vs_fall) begin
      if (state == S_IDLE) state_nx = S_MEAS;
      else if (state == S_MEAS || !match) begin
        state_nx = S_CHECK;
        ref_h_nx = f_h;
        ref_v_nx = f_v;
        cnt_nx   = '0;
      end else if (state == S_CHECK) begin
        cnt_nx   = cnt + 4'd1;
        state_nx = cnt_nx == 4'(LOCK_FRAMES) ? S_LOCK : S_CHECK;
      end
    end
  end
  always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
    if (!VGA_RST_N) begin
      state <= S_IDLE;
      ref_h <= '0;
      ref_v <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      ref_h <= ref_h_nx;
      ref_v <= ref_v_nx;
      cnt   <= cnt_nx;
    end
  end
  always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
    if (!VGA_RST_N) begin
      {hs1, hs2, vs1, vs2, de1, de2} <= '0;
      rgb1        <= '0;
      h_cnt       <= '0;
      to_cnt      <= '0;
      x           <= '0;
      f_h         <= '0;
      f_v         <= '0;
      bad         <= 1'b0;
      H_TOTAL     <= '0;
      FRAME_START <= 1'b0;
      PIX_VALID   <= 1'b0;
      PIX_X       <= '0;
      PIX_Y       <= '0;
      PIX_RGB     <= '0;
    end else begin
      {hs1, hs2, vs1, vs2, de1, de2} <= {VGA_HSYNC, hs1, VGA_VSYNC, vs1, VGA_DE, de1};
      rgb1 <= {VGA_R, VGA_G, VGA_B};
      if (hs_fall) begin
        h_cnt   <= '0;
        to_cnt  <= '0;
        H_TOTAL <= h_cnt + H_W'(1);
      end else begin
        h_cnt  <= h_cnt != '1 ? h_cnt + H_W'(1) : h_cnt;
        to_cnt <= to_cnt != T_W'(TIMEOUT) ? to_cnt + T_W'(1) : to_cnt;
      end
      if (de1) x <= x_cur + H_W'(1);
      // a line still open across the VSYNC fall is credited to the new frame
      if (vs_fall) begin
        f_v <= V_W'(de_fall);
        f_h <= de_fall ? x : '0;
        bad <= 1'b0;
      end else begin
        if (de_fall) begin
          if (f_v == '0) f_h <= x;
          else if (x != f_h) bad <= 1'b1;
          if (f_v != '1) f_v <= f_v + V_W'(1);
        end
        if (pix_bad) bad <= 1'b1;
      end
      FRAME_START <= vs_fall;
      PIX_VALID   <= locked && de1;
      if (locked && de1) begin
        PIX_X   <= x_cur;
        PIX_Y   <= vs_fall ? '0 : f_v;
        PIX_RGB <= rgb1;
      end
    end
  end
`ifdef VGA_RX_ERRCNT_EN
  logic loss;
  logic [15:0] err_cnt;
  assign loss    = locked && (timeout || (vs_fall && !match));
  assign ERR_CNT = err_cnt;
  always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
    if (!VGA_RST_N) err_cnt <= '0;
    else if (loss && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
`else
  assign ERR_CNT = '0;
`endif
endmodule

// File: tb/tb_vga_rx_capture_8b.sv
// tb_vga_rx_capture_8b: scoreboard bench for vga_rx_capture_8b on small directed VGA formats.
module tb_vga_rx_capture_8b;
  localparam int H_W = 11;
  localparam int V_W = 10;
  localparam int TO  = 200;
`ifdef VGA_RX_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, hs = 1'b1, vs = 1'b1, de = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;
  logic pix_valid, frame_start, locked;
  logic [H_W-1:0] pix_x, h_active, h_total;
  logic [V_W-1:0] pix_y, v_active;
  logic [23:0] pix_rgb;
  logic [15:0] err_cnt;
  vga_rx_capture_8b #(.H_W(H_W), .V_W(V_W), .LOCK_FRAMES(2), .TIMEOUT(TO)) dut (
    .VGA_CLK(clk), .VGA_RST_N(rst_n), .VGA_HSYNC(hs), .VGA_VSYNC(vs), .VGA_DE(de),
    .VGA_R(r), .VGA_G(g), .VGA_B(b), .PIX_VALID(pix_valid), .PIX_X(pix_x), .PIX_Y(pix_y),
    .PIX_RGB(pix_rgb), .FRAME_START(frame_start), .LOCKED(locked), .H_ACTIVE(h_active),
    .V_ACTIVE(v_active), .H_TOTAL(h_total), .ERR_CNT(err_cnt)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [H_W-1:0] x;
    logic [V_W-1:0] y;
    logic [23:0]    rgb;
  } pix_t;
  typedef struct packed {
    logic           lock;
    logic [H_W-1:0] hact;
    logic [V_W-1:0] vact;
    logic [H_W-1:0] htot;
    logic           chk_htot;
  } fs_t;
  pix_t pq[$];
  fs_t  fq[$];
  pix_t pe;
  fs_t  fe;
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic fs_t mkfs(input bit l, input int ha, input int va, input int ht, input bit c);
    fs_t f;
    f.lock = l;
    f.hact = H_W'(ha);
    f.vact = V_W'(va);
    f.htot = H_W'(ht);
    f.chk_htot = c;
    return f;
  endfunction
  always @(negedge clk) begin
    if (frame_start) begin
      if (fq.size() == 0) chk("unexpected_frame_start", 64'(1), 64'(0));
      else begin
        fe = fq.pop_front();
        chk("locked_at_fs", 64'(locked), 64'(fe.lock));
        chk("h_active_at_fs", 64'(h_active), 64'(fe.hact));
        chk("v_active_at_fs", 64'(v_active), 64'(fe.vact));
        if (fe.chk_htot) chk("h_total_at_fs", 64'(h_total), 64'(fe.htot));
      end
    end
    if (pix_valid) begin
      if (pq.size() == 0) chk("unexpected_pixel", 64'({pix_x, pix_y, pix_rgb}), 64'(0));
      else begin
        pe = pq.pop_front();
        chk("pixel_xyrgb", 64'({pix_x, pix_y, pix_rgb}), 64'(pe));
      end
    end
  end
  task automatic tick(input logic h, input logic v, input logic d, input logic [23:0] rgb);
    @(posedge clk);
    #1;
    hs = h;
    vs = v;
    de = d;
    {r, g, b} = rgb;
  endtask
  // line = 4 HSYNC low, 4 back porch, ha active, 4 front porch; frame = VS line, VBP line, va active, VFP line
  task automatic drive_frame(input int ha, input int va, input int sl, input int nl, input bit ep, input fs_t e);
    pix_t p;
    fq.push_back(e);
    for (int ln = 0; ln < va + 3 && ln < nl; ln++)
      for (int c = 0; c < ha + 12; c++) begin
        int x, y, len;
        bit d;
        logic [7:0] xb, yb;
        x = c - 8;
        y = ln - 2;
        len = (y == sl) ? 10 : ha;
        d = ln >= 2 && ln < va + 2 && x >= 0 && x < len;
        xb = 8'(x);
        yb = 8'(y);
        tick(c >= 4, ln != 0, d, {xb, yb, xb ^ 8'hA5});
        if (d && ep) begin
          p.x = H_W'(x);
          p.y = V_W'(y);
          p.rgb = {xb, yb, xb ^ 8'hA5};
          pq.push_back(p);
        end
      end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_valid", 64'(pix_valid), 64'(0));
    chk("rst_pix_xy", 64'({pix_x, pix_y}), 64'(0));
    chk("rst_pix_rgb", 64'(pix_rgb), 64'(0));
    chk("rst_frame_start", 64'(frame_start), 64'(0));
    chk("rst_locked", 64'(locked), 64'(0));
    chk("rst_active", 64'({h_active, v_active}), 64'(0));
    chk("rst_h_total", 64'(h_total), 64'(0));
    chk("rst_err_cnt", 64'(err_cnt), 64'(0));
    rst_n = 1'b1;
    repeat (5) tick(1, 1, 0, 0);
    drive_frame(16, 6, -1, 99, 0, mkfs(0, 0, 0, 0, 0));
    drive_frame(16, 6, -1, 99, 0, mkfs(0, 0, 0, 28, 1));
    drive_frame(16, 6, -1, 99, 0, mkfs(0, 0, 0, 28, 1));
    drive_frame(16, 6, -1, 99, 1, mkfs(1, 16, 6, 28, 1));
    drive_frame(16, 6, 3, 99, 1, mkfs(1, 16, 6, 28, 1));
    drive_frame(16, 6, -1, 99, 0, mkfs(0, 0, 0, 28, 1));
    chk("err_after_short_line", 64'(err_cnt), ERR_EN ? 64'(1) : 64'(0));
    drive_frame(16, 6, -1, 99, 0, mkfs(0, 0, 0, 28, 1));
    drive_frame(16, 6, -1, 99, 1, mkfs(1, 16, 6, 28, 1));
    chk("locked_before_timeout", 64'(locked), 64'(1));
    repeat (TO + 20) tick(1, 1, 0, 0);
    chk("locked_after_timeout", 64'(locked), 64'(0));
    chk("active_after_timeout", 64'({h_active, v_active}), 64'(0));
    chk("err_after_timeout", 64'(err_cnt), ERR_EN ? 64'(2) : 64'(0));
    drive_frame(16, 6, -1, 99, 0, mkfs(0, 0, 0, 0, 0));
    drive_frame(16, 6, -1, 99, 0, mkfs(0, 0, 0, 28, 1));
    drive_frame(16, 6, -1, 99, 0, mkfs(0, 0, 0, 28, 1));
    drive_frame(16, 6, -1, 99, 1, mkfs(1, 16, 6, 28, 1));
    drive_frame(12, 4, -1, 99, 1, mkfs(1, 16, 6, 28, 1));
    drive_frame(12, 4, -1, 99, 0, mkfs(0, 0, 0, 24, 1));
    drive_frame(12, 4, -1, 99, 0, mkfs(0, 0, 0, 24, 1));
    drive_frame(12, 4, -1, 99, 1, mkfs(1, 12, 4, 24, 1));
    chk("err_after_format_switch", 64'(err_cnt), ERR_EN ? 64'(3) : 64'(0));
    drive_frame(12, 4, -1, 3, 1, mkfs(1, 12, 4, 24, 1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_locked", 64'(locked), 64'(0));
    chk("midrst_outputs", 64'({pix_valid, pix_x, pix_y, pix_rgb, frame_start}), 64'(0));
    chk("midrst_geometry", 64'({h_active, v_active, h_total, err_cnt}), 64'(0));
    repeat (3) tick(1, 1, 0, 0);
    rst_n = 1'b1;
    repeat (5) tick(1, 1, 0, 0);
    drive_frame(12, 4, -1, 99, 0, mkfs(0, 0, 0, 0, 0));
    drive_frame(12, 4, -1, 99, 0, mkfs(0, 0, 0, 24, 1));
    drive_frame(12, 4, -1, 99, 0, mkfs(0, 0, 0, 24, 1));
    drive_frame(12, 4, -1, 99, 1, mkfs(1, 12, 4, 24, 1));
    drive_frame(12, 4, -1, 1, 0, mkfs(1, 12, 4, 24, 1));
    repeat (10) tick(1, 1, 0, 0);
    chk("pixel_queue_drained", 64'(pq.size()), 64'(0));
    chk("fs_queue_drained", 64'(fq.size()), 64'(0));
    chk("final_locked", 64'(locked), 64'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
